sh_rgst_ctrl: RTL and testbench
===============================

# sh_rgst_ctrl

Sequencer that shares one `sh_rgst` shift register between two requesters. It accepts shift commands (data, direction, amount) over valid/ready handshakes and arbitrates round-robin between the requesters. It loads the register, then splits shift amounts larger than 15 into successive steps of at most 15. It returns the shifted word with the requester ID over a valid/ready response channel. It sits between the client logic and the register's `d`/`ld`/`sh_dir`/`sh_pos`/`q` pins.

## Interface
- `W`, 8: data width; must match the attached register.
- `AMT_W`, 5: command shift-amount width; maximum shift is 2^AMT_W-1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  command present.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle.
- `req0_data`, `req1_data`  in  W  word to load.
- `req0_dir`, `req1_dir`  in  1  0 = left, 1 = right.
- `req0_amt`, `req1_amt`  in  AMT_W  total shift amount.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  W  shifted word; equals `reg_q`.
- `rsp_id`  out  1  requester that issued the command.
- `reg_d`  out  W  to register `d`.
- `reg_ld`  out  1  to register `ld`.
- `reg_dir`  out  1  to register `sh_dir`.
- `reg_pos`  out  4  to register `sh_pos`.
- `reg_q`  in  W  from register `q`.

## Operation
- The register shifts on every edge with `ld`=0, so the block holds the register by driving `reg_pos`=0 in every state except SHIFT.
- States: IDLE, LOAD, SHIFT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `reqN_valid` is high, the arbiter grants one requester.
  - `reqN_ready`=1 for the granted requester only, combinationally. Both are 0 in all other states.
  - On acceptance, capture data, dir, amt and id into `rem`; next state is LOAD.
- **LOAD**
  - `reg_ld`=1 and `reg_d`=captured data for one cycle.
  - Next state is SHIFT if `rem`≠0, otherwise RESP.
- **SHIFT**
  - `reg_pos`=min(`rem`,15) and `rem` ← `rem` − `reg_pos`.
  - Next state is RESP when the step just issued makes `rem` zero.
- **RESP**
  - `rsp_valid`=1, `rsp_data`=`reg_q`, `rsp_id`=captured id.
  - When `rsp_ready`=1, return to IDLE.
  - The result is held stable while `rsp_ready`=0.
- Round-robin arbitration:
  - The `last` pointer updates on acceptance.
  - When both requesters are valid, the grant goes to the requester ≠ `last`.
  - A single valid requester is always granted.
  - `last` resets to 1, so req0 wins the first tie.
- Arithmetic: the shift is logical (zero-fill). Amounts ≥ W yield 0; the block does not clamp.
- `reg_dir` equals the captured dir throughout a transaction and holds its value in IDLE.

## Timing
- Reset values:
  - state=IDLE, `last`=1, `rem`=0.
  - `reqN_ready`=0, `rsp_valid`=0, `rsp_id`=0.
  - `reg_ld`=0, `reg_pos`=0, `reg_dir`=0, `reg_d`=0.
- With acceptance in cycle T:
  - LOAD occurs in T+1.
  - SHIFT occurs in T+2 … T+1+S, where S=ceil(amt/15).
  - `rsp_valid` rises in T+2+S.
  - For amt=0, `rsp_valid` rises in T+2.
- Throughput: the next acceptance is possible no earlier than the cycle after the `rsp_valid`&&`rsp_ready` handshake.
- A requester whose valid is pending while the block is busy waits; it is not dropped.
- Reset mid-transaction:
  - The in-flight command is discarded.
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - No response is produced.

## Structure
- Package `sh_ctrl_pkg`:
  - state enum (IDLE/LOAD/SHIFT/RESP).
  - `MAX_STEP`=15.
  - `POS_W`=4.
- Sub-module `rr_arb2`:
  - Two-input round-robin arbiter.
  - Inputs: `req[1:0]`, `last`. Outputs: `grant[1:0]`.
  - Combinational.
- Top-level FSM, capture registers and `rem` counter live in `sh_rgst_ctrl`.

## Test plan
- W=8, req0 data 0x01, dir 0, amt 3 → `reg_pos`=3 for one cycle; `rsp_data`=0x08, `rsp_id`=0 at T+3.
- W=32, req1 data 0x0000_0001, dir 0, amt 20 → `reg_pos` sequence 15, 5; `rsp_data`=0x0010_0000, `rsp_id`=1 at T+4.
- Both valid in the same cycle after reset → req0 served first, then req1; on the next tie, req0 wins again because `last`=1.
- amt=0, data 0xA5 → no SHIFT cycles; `rsp_data`=0xA5 at T+2. Hold `rsp_ready`=0 for 3 cycles → data and id stable, no new `req_ready` asserted.
- W=8, data 0x80, dir 1, amt 31 → `reg_pos` sequence 15, 15, 1; `rsp_data`=0x00.
- Assert `rst_b`=0 during SHIFT → outputs go to reset values immediately; after release, a new req0 command completes normally.

Source files
------------

// File: rtl/sh_rgst_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
// The register moves at most MAX_STEP positions per clock, so larger amounts are split.
package sh_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int MAX_STEP = 15;
    localparam int POS_W    = 4;

endpackage

// File: rtl/sh_rgst_ctrl_if.sv
// Command, response and register-pin bundle around the sequencer.
// slave = controller view; master = clients plus the attached register.
interface sh_rgst_ctrl_if #(
    parameter int W     = 8,
    parameter int AMT_W = 5
);
    import sh_ctrl_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_data;
    logic             req0_dir;
    logic [AMT_W-1:0] req0_amt;
    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_data;
    logic             req1_dir;
    logic [AMT_W-1:0] req1_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             rsp_id;
    logic [W-1:0]     reg_d;
    logic             reg_ld;
    logic             reg_dir;
    logic [POS_W-1:0] reg_pos;
    logic [W-1:0]     reg_q;

    modport slave (
        input  req0_valid, req0_data, req0_dir, req0_amt,
        input  req1_valid, req1_data, req1_dir, req1_amt,
        input  rsp_ready, reg_q,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output reg_d, reg_ld, reg_dir, reg_pos
    );

    modport master (
        output req0_valid, req0_data, req0_dir, req0_amt,
        output req1_valid, req1_data, req1_dir, req1_amt,
        output rsp_ready, reg_q,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  reg_d, reg_ld, reg_dir, reg_pos
    );
endinterface

// File: rtl/sh_rgst_ctrl_arb.sv
// Two-input round-robin arbiter, purely combinational; on a tie the grant
// goes to the requester that was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[0] = req[0] & (~req[1] |  last);
    assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/sh_rgst_ctrl.sv
// Shares one shift register between two requesters: accept, load, shift in <=15 steps, respond.
// Latency accept->rsp_valid = 2+ceil(amt/15) cycles; one command in flight, response held until rsp_ready.
module sh_rgst_ctrl
    import sh_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int AMT_W = 5
) (
    input  logic           clk,
    input  logic           rst_b,
    sh_rgst_ctrl_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [W-1:0]     r_data;
    logic             r_dir;
    logic             r_id;
    logic [AMT_W-1:0] r_rem;

    logic [1:0]       w_grant;
    logic             w_accept;
    logic [POS_W-1:0] w_step;

    rr_arb2 u_arb (
        .req   ({bus.req1_valid, bus.req0_valid}),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_step = (r_rem > AMT_W'(MAX_STEP)) ? POS_W'(MAX_STEP) : r_rem[POS_W-1:0];

    assign bus.rsp_data = bus.reg_q;
    assign bus.rsp_id   = r_id;
    assign bus.reg_dir  = r_dir;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_id    <= 1'b0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_grant[1];
                r_id   <= w_grant[1];
                r_data <= w_grant[1] ? bus.req1_data : bus.req0_data;
                r_dir  <= w_grant[1] ? bus.req1_dir  : bus.req0_dir;
                r_rem  <= w_grant[1] ? bus.req1_amt  : bus.req0_amt;
            end else if (r_state == ST_SHIFT) begin
                r_rem <= r_rem - AMT_W'(w_step);
            end
        end
    end

    // reg_pos stays 0 outside SHIFT: the register shifts on every non-load edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.reg_ld     = 1'b0;
        bus.reg_d      = '0;
        bus.reg_pos    = '0;
        case (r_state)
            ST_IDLE: begin
                bus.req0_ready = w_grant[0];
                bus.req1_ready = w_grant[1];
                if (|w_grant) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.reg_ld  = 1'b1;
                bus.reg_d   = r_data;
                w_state_nxt = (r_rem != '0) ? ST_SHIFT : ST_RESP;
            end
            ST_SHIFT: begin
                bus.reg_pos = w_step;
                if (r_rem == AMT_W'(w_step)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sh_rgst_ctrl.sv
// Bench for sh_rgst_ctrl with a behavioural shift register attached to the register pins.
// Expected results come from whole-word shift arithmetic on each command.
module tb_sh_rgst_ctrl;
    import sh_ctrl_pkg::*;

    localparam int W     = 32;
    localparam int AMT_W = 6;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    sh_rgst_ctrl_if #(.W(W), .AMT_W(AMT_W)) bus ();

    sh_rgst_ctrl #(.W(W), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // Attached register: loads on ld, otherwise shifts by sh_pos every edge.
    logic [W-1:0] q_m = '0;
    always @(posedge clk) begin
        if (bus.reg_ld)       q_m <= bus.reg_d;
        else if (bus.reg_dir) q_m <= q_m >> bus.reg_pos;
        else                  q_m <= q_m << bus.reg_pos;
    end
    assign bus.reg_q = q_m;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic dir,
                                               input logic [AMT_W-1:0] amt);
        logic [W-1:0] r;
        r = dir ? (d >> amt) : (d << amt);
        return r;
    endfunction

    task automatic set_req(input int id, input logic [W-1:0] d, input logic dir,
                           input logic [AMT_W-1:0] amt);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_dir = dir; bus.req0_amt = amt;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_dir = dir; bus.req1_amt = amt;
        end
    endtask

    // Waits for the grant of a command already presented, then follows it to the response.
    task automatic serve(input int id, input logic [W-1:0] d, input logic dir,
                         input logic [AMT_W-1:0] amt, input int hold);
        int n;
        int rem;
        int step;
        logic [W-1:0] exp;
        exp = ref_shift(d, dir, amt);
        n = 0;
        #1;
        while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", n >= 40, 0);
        chk("other_ready_low", (id == 0) ? bus.req1_ready : bus.req0_ready, 0);
        @(negedge clk);
        if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        #1;
        chk("load_ld", bus.reg_ld, 1);
        chk("load_d", bus.reg_d, d);
        chk("load_dir", bus.reg_dir, dir);
        chk("load_pos", bus.reg_pos, 0);
        rem = int'(amt);
        while (rem > 0) begin
            step = (rem > 15) ? 15 : rem;
            rem -= step;
            @(negedge clk); #1;
            chk("shift_pos", bus.reg_pos, step);
            chk("shift_ld", bus.reg_ld, 0);
            chk("shift_rsp_vld", bus.rsp_valid, 0);
        end
        @(negedge clk); #1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_data", bus.rsp_data, exp);
        chk("rsp_id", bus.rsp_id, id);
        repeat (hold) begin
            @(negedge clk); #1;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, exp);
            chk("hold_id", bus.rsp_id, id);
            chk("hold_ready0", bus.req0_ready, 0);
            chk("hold_ready1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("idle_rsp_vld", bus.rsp_valid, 0);
    endtask

    initial begin
        int n;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_dir = 1'b0; bus.req0_amt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_dir = 1'b0; bus.req1_amt = '0;
        bus.rsp_ready  = 1'b0;
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_ld", bus.reg_ld, 0);
        chk("rst_pos", bus.reg_pos, 0);
        chk("rst_dir", bus.reg_dir, 0);
        chk("rst_d", bus.reg_d, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        // Basic left shift by 3, then a split 15+5 shift from req1.
        set_req(0, 32'h0000_0001, 1'b0, 6'd3);
        serve(0, 32'h0000_0001, 1'b0, 6'd3, 0);
        set_req(1, 32'h0000_0001, 1'b0, 6'd20);
        serve(1, 32'h0000_0001, 1'b0, 6'd20, 0);

        // Two ties in a row: req0 first each time, the waiting req1 is not dropped.
        repeat (2) begin
            set_req(0, 32'h0000_0011, 1'b0, 6'd1);
            set_req(1, 32'h0000_2200, 1'b1, 6'd2);
            serve(0, 32'h0000_0011, 1'b0, 6'd1, 0);
            serve(1, 32'h0000_2200, 1'b1, 6'd2, 0);
        end

        // Zero amount with a stalled consumer while req1 waits.
        set_req(1, 32'h1234_5678, 1'b1, 6'd4);
        set_req(0, 32'h0000_00A5, 1'b0, 6'd0);
        serve(0, 32'h0000_00A5, 1'b0, 6'd0, 3);
        serve(1, 32'h1234_5678, 1'b1, 6'd4, 0);

        // 15,15,1 split, then an amount beyond the word width.
        set_req(0, 32'h0000_0080, 1'b1, 6'd31);
        serve(0, 32'h0000_0080, 1'b1, 6'd31, 0);
        set_req(1, 32'hFFFF_FFFF, 1'b0, 6'd63);
        serve(1, 32'hFFFF_FFFF, 1'b0, 6'd63, 1);

        // Reset in the middle of a shift from req1 with dir=1.
        set_req(1, 32'hF000_000F, 1'b1, 6'd40);
        n = 0;
        #1;
        while (!bus.req1_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk("rst_accept_timeout", n >= 40, 0);
        @(negedge clk); bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_pos", bus.reg_pos, 15);
        #1 rst_b = 1'b0;
        #1;
        chk("mid_rst_pos", bus.reg_pos, 0);
        chk("mid_rst_dir", bus.reg_dir, 0);
        chk("mid_rst_id", bus.rsp_id, 0);
        chk("mid_rst_vld", bus.rsp_valid, 0);
        chk("mid_rst_ld", bus.reg_ld, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post_rst_no_rsp", bus.rsp_valid, 0);
        end
        set_req(0, 32'h0000_0003, 1'b0, 6'd2);
        serve(0, 32'h0000_0003, 1'b0, 6'd2, 0);

        // Randomized commands.
        for (int i = 0; i < 25; i++) begin
            int id;
            logic [W-1:0] d;
            logic dir;
            logic [AMT_W-1:0] amt;
            int hold;
            id   = int'($urandom_range(0, 1));
            d    = $urandom;
            dir  = 1'($urandom_range(0, 1));
            amt  = AMT_W'($urandom_range(0, 63));
            hold = int'($urandom_range(0, 2));
            set_req(id, d, dir, amt);
            serve(id, d, dir, amt, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
